// File: rtl/control_unit_if.sv
// control_unit_if: instruction-memory, register-file and ALU control signals of the control unit
interface control_unit_if;
  logic [7:0] instr_addr;
  logic [7:0] instr_data;
  logic       instr_valid;
  logic [1:0] reg_a_sel;
  logic [1:0] reg_b_sel;
  logic [1:0] reg_wr_sel;
  logic       reg_wr_en;
  logic [2:0] alu_op;
  logic       wb_src;
  logic [7:0] imm;
  logic       alu_zero;
  logic       alu_carry;
  logic       halted;
  modport master (
    output instr_addr, reg_a_sel, reg_b_sel, reg_wr_sel, reg_wr_en, alu_op, wb_src, imm, halted,
    input  instr_data, instr_valid, alu_zero, alu_carry
  );
  modport slave (
    input  instr_addr, reg_a_sel, reg_b_sel, reg_wr_sel, reg_wr_en, alu_op, wb_src, imm, halted,
    output instr_data, instr_valid, alu_zero, alu_carry
  );
endinterface

// File: rtl/control_unit.sv
// control_unit: multi-cycle fetch/decode/execute sequencer for an 8-bit, 4-register datapath
module control_unit (
  input  logic          clk,
  input  logic          reset,
  control_unit_if.master bus
);
  typedef enum logic [2:0] {FETCH, DECODE, FETCH_IMM, EXECUTE, WRITEBACK, HALT} state_t;
  state_t     state_q, state_d;
  logic [7:0] pc_q, pc_d, ir_q, ir_d, imm_q, imm_d;
  logic       z_q, z_d, c_q, c_d;
  logic [3:0] op;
  logic       is_alu, two_byte;
  assign op       = ir_q[7:4];
  assign is_alu   = (op >= 4'h1 && op <= 4'h5) || op == 4'hB;
  assign two_byte = op >= 4'h7 && op <= 4'hA;
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    imm_d   = imm_q;
    z_d     = z_q;
    c_d     = c_q;
    case (state_q)
      FETCH: if (bus.instr_valid) begin
        ir_d    = bus.instr_data;
        pc_d    = pc_q + 8'd1;
        state_d = DECODE;
      end
      DECODE: state_d = op == 4'hF ? HALT :
                        (op == 4'h0 || op >= 4'hC) ? FETCH :
                        two_byte ? FETCH_IMM : EXECUTE;
      FETCH_IMM: if (bus.instr_valid) begin
        imm_d   = bus.instr_data;
        pc_d    = pc_q + 8'd1;
        state_d = EXECUTE;
      end
      EXECUTE: begin
        if (is_alu) begin
          z_d = bus.alu_zero;
          c_d = bus.alu_carry;
        end
        if (op == 4'h8 || (op == 4'h9 && z_q) || (op == 4'hA && c_q)) pc_d = imm_q;
        state_d = (op == 4'h6 || op == 4'h7 || (is_alu && op != 4'hB)) ? WRITEBACK : FETCH;
      end
      WRITEBACK: state_d = FETCH;
      default: ;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
      pc_q    <= 8'h00;
      ir_q    <= 8'h00;
      imm_q   <= 8'h00;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      imm_q   <= imm_d;
      z_q     <= z_d;
      c_q     <= c_d;
    end
  end
  assign bus.instr_addr = pc_q;
  assign bus.reg_a_sel  = ir_q[3:2];
  assign bus.reg_b_sel  = ir_q[1:0];
  assign bus.reg_wr_sel = ir_q[3:2];
  assign bus.reg_wr_en  = state_q == WRITEBACK;
  assign bus.wb_src     = op == 4'h7;
  assign bus.imm        = imm_q;
  assign bus.halted     = state_q == HALT;
  assign bus.alu_op     = op == 4'h1 ? 3'd0 :
                          (op == 4'h2 || op == 4'hB) ? 3'd1 :
                          op == 4'h3 ? 3'd2 :
                          op == 4'h4 ? 3'd3 :
                          op == 4'h5 ? 3'd4 :
                          op == 4'h6 ? 3'd5 : 3'd0;
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: randomized programs run against an instruction-level model, scoreboarded on writes and halts
module tb_control_unit;
  typedef struct packed {
    logic       halt;
    logic [1:0] rd;
    logic [1:0] rs;
    logic [2:0] op;
    logic       wb;
    logic [7:0] val;
  } ev_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int errors = 0;
  int checks = 0;
  int wr_count = 0;
  ev_t q[$];
  logic halt_prev = 1'b0;
  logic [7:0] exp_halt_pc;
  logic [7:0] mem [256];
  logic [7:0] regs [4];
  logic [7:0] ra, rb;
  logic [8:0] alu_res;
  control_unit_if bus();
  control_unit dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  assign bus.instr_data = mem[bus.instr_addr];
  assign ra = regs[bus.reg_a_sel];
  assign rb = regs[bus.reg_b_sel];
  always_comb begin
    alu_res = {1'b0, rb};
    case (bus.alu_op)
      3'd0: alu_res = {1'b0, ra} + {1'b0, rb};
      3'd1: alu_res = {1'b0, ra} - {1'b0, rb};
      3'd2: alu_res = {1'b0, ra & rb};
      3'd3: alu_res = {1'b0, ra | rb};
      3'd4: alu_res = {1'b0, ra ^ rb};
      default: alu_res = {1'b0, rb};
    endcase
  end
  assign bus.alu_zero  = alu_res[7:0] == 8'h00;
  assign bus.alu_carry = alu_res[8];
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) regs[i] <= 8'h00;
    end else if (bus.reg_wr_en) begin
      regs[bus.reg_wr_sel] <= bus.wb_src ? bus.imm : alu_res[7:0];
    end
  end
  always @(posedge clk) if (bus.reg_wr_en) wr_count <= wr_count + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] exp_op(input logic [3:0] op);
    return op == 4'h1 ? 3'd0 : op == 4'h2 ? 3'd1 : op == 4'h3 ? 3'd2 :
           op == 4'h4 ? 3'd3 : op == 4'h5 ? 3'd4 : 3'd5;
  endfunction

  // Instruction-level interpreter: runs the memory image and queues every register write and the halt.
  task automatic model(output bit ok);
    logic [7:0] r [4];
    logic [7:0] pc, ir, im, a, b, res;
    logic [3:0] op;
    logic [1:0] rd, rs;
    logic z, c;
    q.delete();
    for (int i = 0; i < 4; i++) r[i] = 8'h00;
    pc = 8'h00; im = 8'h00; z = 1'b0; c = 1'b0; ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      ir = mem[pc]; pc = pc + 8'd1;
      op = ir[7:4]; rd = ir[3:2]; rs = ir[1:0];
      if (op >= 4'h7 && op <= 4'hA) begin
        im = mem[pc]; pc = pc + 8'd1;
      end
      a = r[rd]; b = r[rs];
      if ((op >= 4'h1 && op <= 4'h5) || op == 4'hB) begin
        res = op == 4'h1 ? a + b : op == 4'h3 ? a & b : op == 4'h4 ? a | b : op == 4'h5 ? a ^ b : a - b;
        c = op == 4'h1 ? ({1'b0, a} + {1'b0, b} > 9'd255) : (op == 4'h2 || op == 4'hB) ? (a < b) : 1'b0;
        z = res == 8'h00;
        if (op != 4'hB) begin
          r[rd] = res;
          q.push_back({1'b0, rd, rs, exp_op(op), 1'b0, res});
        end
      end else if (op == 4'h6) begin
        r[rd] = b;
        q.push_back({1'b0, rd, rs, exp_op(op), 1'b0, b});
      end else if (op == 4'h7) begin
        r[rd] = im;
        q.push_back({1'b0, rd, rs, 3'd0, 1'b1, im});
      end else if (op == 4'h8 || (op == 4'h9 && z) || (op == 4'hA && c)) begin
        pc = im;
      end else if (op == 4'hF) begin
        q.push_back({1'b1, 2'b00, 2'b00, 3'd0, 1'b0, pc});
        exp_halt_pc = pc;
        ok = 1'b1;
        return;
      end
    end
  endtask

  always @(negedge clk) begin
    ev_t e;
    if (reset) begin
      halt_prev = 1'b0;
    end else begin
      if (bus.reg_wr_en) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: got write to r%0d with no event pending", bus.reg_wr_sel);
        end else begin
          e = q.pop_front();
          chk("event_is_write", {31'd0, e.halt}, 32'd0);
          if (!e.halt) begin
            chk("wr_sel", bus.reg_wr_sel, e.rd);
            chk("a_sel", bus.reg_a_sel, e.rd);
            chk("b_sel", bus.reg_b_sel, e.rs);
            chk("wb_src", bus.wb_src, e.wb);
            if (!e.wb) chk("alu_op", bus.alu_op, e.op);
            chk("wr_value", bus.wb_src ? bus.imm : alu_res[7:0], e.val);
          end
        end
      end
      if (bus.halted && !halt_prev) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_halt: got halt at pc %h with no event pending", bus.instr_addr);
        end else begin
          e = q.pop_front();
          chk("event_is_halt", {31'd0, e.halt}, 32'd1);
          chk("halt_pc", bus.instr_addr, e.val);
        end
      end
      halt_prev = bus.halted;
    end
  end

  task automatic prep(input bit valid0);
    bit ok;
    reset = 1'b1;
    bus.instr_valid = valid0;
    #1;
    chk("reset_state", {bus.instr_addr, bus.imm, bus.reg_wr_en, bus.halted}, 32'd0);
    model(ok);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic finish_run(input bit zero_wait, input int hold);
    for (int n = 0; n < 3000 && !bus.halted; n++) begin
      @(posedge clk); #1;
      bus.instr_valid = zero_wait || ($urandom_range(0, 3) != 0);
    end
    if (!bus.halted) begin
      checks++; errors++;
      $display("FAIL halt_timeout: got halted=0 expected halted=1 within 3000 cycles");
      return;
    end
    for (int n = 0; n < hold; n++) begin
      @(posedge clk); #1;
      bus.instr_valid = 1'($urandom_range(0, 1));
      chk("halt_frozen", {bus.halted, bus.reg_wr_en, bus.instr_addr}, {22'd0, 1'b1, 1'b0, exp_halt_pc});
    end
    @(negedge clk); #1;
    chk("pending_events", q.size(), 0);
  endtask

  task automatic fill_halt();
    for (int i = 0; i < 256; i++) mem[i] = 8'hF0;
  endtask

  task automatic load_a();
    fill_halt();
    mem[8'h00] = 8'h74; mem[8'h01] = 8'h05; mem[8'h02] = 8'h70; mem[8'h03] = 8'hFF;
    mem[8'h04] = 8'h11; mem[8'h05] = 8'hA0; mem[8'h06] = 8'h20;
    mem[8'h20] = 8'hB5; mem[8'h21] = 8'h90; mem[8'h22] = 8'h40;
    mem[8'h40] = 8'hB1; mem[8'h41] = 8'h90; mem[8'h42] = 8'h80; mem[8'h43] = 8'h68;
    mem[8'h44] = 8'h5A; mem[8'h45] = 8'hC3; mem[8'h46] = 8'h00; mem[8'h47] = 8'h29;
  endtask

  initial begin
    bit ok;
    bus.instr_valid = 1'b0;
    #2;
    load_a();
    prep(1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("ldi_no_early_write", bus.reg_wr_en, 0);
    @(posedge clk); #1;
    chk("ldi_writeback_cycle5", {bus.reg_wr_en, bus.reg_wr_sel, bus.wb_src, bus.imm, bus.instr_addr},
        {12'd0, 1'b1, 2'b01, 1'b1, 8'h05, 8'h02});
    finish_run(1'b1, 20);
    load_a();
    prep(1'b1);
    for (int n = 0; n < 50 && !bus.reg_wr_en; n++) begin
      @(posedge clk); #1;
    end
    chk("abort_reached_writeback", bus.reg_wr_en, 1);
    reset = 1'b1;
    #1;
    chk("abort_reset_immediate", {bus.reg_wr_en, bus.instr_addr, bus.halted, bus.imm}, 32'd0);
    q.delete();
    begin
      int w0;
      w0 = wr_count;
      repeat (2) @(posedge clk);
      #1;
      chk("abort_no_write", wr_count, w0);
    end
    load_a();
    prep(1'b0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("stall_fetch", {bus.instr_addr, bus.reg_a_sel, bus.reg_b_sel, bus.reg_wr_en, bus.halted}, 32'd0);
    end
    bus.instr_valid = 1'b1;
    @(posedge clk); #1;
    chk("stall_accept", bus.instr_addr, 8'h01);
    finish_run(1'b0, 3);
    fill_halt();
    mem[8'h00] = 8'h00; mem[8'h01] = 8'h00; mem[8'h02] = 8'h00; mem[8'h03] = 8'hF0;
    prep(1'b1);
    finish_run(1'b1, 20);
    fill_halt();
    mem[8'h00] = 8'hB1; mem[8'h01] = 8'h90; mem[8'h02] = 8'hFD; mem[8'h03] = 8'hF0;
    mem[8'hFD] = 8'h00; mem[8'hFE] = 8'h74; mem[8'hFF] = 8'h55;
    prep(1'b1);
    finish_run(1'b0, 2);
    for (int k = 0; k < 20; k++) begin
      do begin
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 255));
        model(ok);
      end while (!ok);
      prep(1'($urandom_range(0, 1)));
      finish_run(k[0], 2);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Parameter: none; all widths fixed (8-bit data, 8-bit program counter, 4 registers).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-004 instr_addr  output  8  instruction-memory byte address; equals pc.
REQ-005 instr_data  input  8  instruction-memory read byte; valid only when instr_valid=1.
REQ-006 instr_valid  input  1  memory-ready strobe; a byte is accepted on any rising clk edge in FETCH or FETCH_IMM with instr_valid=1.
REQ-007 reg_a_sel  output  2  register-file read port 1 select; equals IR[3:2] (rd).
REQ-008 reg_b_sel  output  2  register-file read port 2 select; equals IR[1:0] (rs).
REQ-009 reg_wr_sel  output  2  register-file write select; equals IR[3:2] (rd).
REQ-010 reg_wr_en  output  1  register-file write enable; high only in WRITEBACK.
REQ-011 alu_op  output  3  ALU operation: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 PASS_B.
REQ-012 wb_src  output  1  write-data mux select: 0 = ALU result, 1 = imm.
REQ-013 imm  output  8  registered immediate byte.
REQ-014 alu_zero, alu_carry  input  1 each  combinational ALU flags for the current alu_op and operands.
REQ-015 halted  output  1  high while in HALT.

Function
REQ-016 Instruction byte: IR[7:4] opcode, IR[3:2] rd, IR[1:0] rs.
REQ-017 Opcodes: 0 NOP; 1 ADD; 2 SUB; 3 AND; 4 OR; 5 XOR; 6 MOV rd<-rs; 7 LDI rd<-imm; 8 JMP imm; 9 JZ imm; A JC imm; B CMP (SUB, flags only); F HLT; C-E execute as NOP.
REQ-018 Opcodes 7, 8, 9, A are two-byte: the second byte is the immediate.
REQ-019 States: FETCH, DECODE, FETCH_IMM, EXECUTE, WRITEBACK, HALT; outputs decoded from state and IR only.
REQ-020 FETCH: wait while instr_valid=0; on instr_valid=1, IR<=instr_data, pc<=pc+1, go to DECODE.
REQ-021 DECODE: HLT -> HALT; NOP/C-E -> FETCH; two-byte -> FETCH_IMM; otherwise -> EXECUTE.
REQ-022 FETCH_IMM: wait while instr_valid=0; on instr_valid=1, imm<=instr_data, pc<=pc+1, go to EXECUTE.
REQ-023 EXECUTE (ADD/SUB/AND/OR/XOR/CMP): drive alu_op; latch Z<=alu_zero, C<=alu_carry at end of cycle; CMP -> FETCH, others -> WRITEBACK.
REQ-024 EXECUTE (MOV): alu_op=PASS_B, flags unchanged, -> WRITEBACK; (LDI): wb_src=1, -> WRITEBACK.
REQ-025 EXECUTE (JMP): pc<=imm; (JZ): pc<=imm if Z=1; (JC): pc<=imm if C=1; all -> FETCH; jump conditions use the flag values latched before this instruction.
REQ-026 WRITEBACK: reg_wr_en=1 for exactly one cycle, alu_op/wb_src/selects held at EXECUTE values, -> FETCH.
REQ-027 reg_wr_en=0 in every state other than WRITEBACK.
REQ-028 pc increments modulo 256 (0xFF -> 0x00); an immediate fetched at 0xFF comes from address 0xFF, next pc 0x00.
REQ-029 HALT: pc, IR, flags frozen; instr_valid ignored; exit only by reset.
REQ-030 Cycle count with zero-wait memory: ALU op 4, CMP 3, MOV 4, LDI 5, jumps 4, NOP 2.

Reset
REQ-031 On reset assertion, immediately: state=FETCH, pc=0x00, IR=0x00, imm=0x00, Z=C=0, reg_wr_en=0, halted=0.
REQ-032 Reset asserted mid-instruction (including WRITEBACK) aborts it with no write; after release, fetch restarts at 0x00.

Verification
REQ-033 Program 0x74,0x05 (LDI r1,5) zero-wait -> reg_wr_en=1 in cycle 5 with reg_wr_sel=01, wb_src=1, imm=0x05, pc=0x02.
REQ-034 ADD r0,r1 (0x11) with alu_zero=0, alu_carry=1 -> alu_op=000, reg_a_sel=00, reg_b_sel=01, one write to r0, C=1 afterwards.
REQ-035 CMP setting Z=1, then JZ 0x40 (0x90,0x40) -> pc=0x40 and instr_addr=0x40 in next FETCH; with Z=0, pc=next sequential address.
REQ-036 instr_valid held low 3 cycles in FETCH -> state, pc, IR unchanged, reg_wr_en=0; accepted on 4th cycle.
REQ-037 HLT (0xF0) at pc 0x03 -> halted=1, pc=0x04 frozen for 20 cycles; reset -> halted=0, instr_addr=0x00.
REQ-038 Reset pulse during WRITEBACK of ADD -> reg_wr_en drops immediately, no write occurs, pc=0x00.
